// File: rtl/ddr_test_pkg.sv
// Shared types and constants for the DDR AXI pattern tester.
package ddr_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [1:0] ABURST_INCR = 2'b01;
  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic       ATYPE_RD    = 1'b0;

  // AXI size code is log2 of the number of bytes per beat.
  function automatic logic [2:0] asizeFromWidth(input int dataW);
    return 3'($clog2(dataW / 8));
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Deterministic test pattern: lane i of global beat k is seed + k*lanes + i.
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic [31:0]       seed_i,
  input  logic [31:0]       beatKey_i,
  output logic [DATA_W-1:0] word_o
);

  localparam int LANES = DATA_W / 32;

  // Build every 32-bit lane from the seed and the global beat index.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < LANES; i++) begin
      word_o[i*32 +: 32] = seed_i + beatKey_i * 32'(LANES) + 32'(i);
    end
  end

endmodule

// File: rtl/ddr_axi_pattern_tester.sv
// Writes BurstNum INCR bursts of a seeded pattern to DDR port 0, reads them
// back, and reports error count and the first failing byte address.
module ddr_axi_pattern_tester
  import ddr_test_pkg::*;
#(
  parameter int               DATA_W    = 256,
  parameter int               ADDR_W    = 32,
  parameter int               BURST_LEN = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                Axi0Clk,
  input  logic                Axi0Rstn,
  input  logic                Start,
  input  logic [31:0]         PatSeed,
  input  logic [15:0]         BurstNum,
  output logic                DdrCtrl_AVALID,
  input  logic                DdrCtrl_AREADY,
  output logic [ADDR_W-1:0]   DdrCtrl_AADDR,
  output logic                DdrCtrl_ATYPE,
  output logic [7:0]          DdrCtrl_ALEN,
  output logic [2:0]          DdrCtrl_ASIZE,
  output logic [1:0]          DdrCtrl_ABURST,
  output logic [1:0]          DdrCtrl_ALOCK,
  output logic [7:0]          DdrCtrl_AID,
  output logic [7:0]          DdrCtrl_WID,
  output logic                DdrCtrl_WVALID,
  input  logic                DdrCtrl_WREADY,
  output logic [DATA_W-1:0]   DdrCtrl_WDATA,
  output logic [DATA_W/8-1:0] DdrCtrl_WSTRB,
  output logic                DdrCtrl_WLAST,
  input  logic                DdrCtrl_BVALID,
  output logic                DdrCtrl_BREADY,
  input  logic [7:0]          DdrCtrl_BID,
  input  logic                DdrCtrl_RVALID,
  output logic                DdrCtrl_RREADY,
  input  logic [DATA_W-1:0]   DdrCtrl_RDATA,
  input  logic                DdrCtrl_RLAST,
  input  logic [1:0]          DdrCtrl_RRESP,
  input  logic [7:0]          DdrCtrl_RID,
  output logic                Busy,
  output logic                Done,
  output logic                Pass,
  output logic [15:0]         ErrCnt,
  output logic [ADDR_W-1:0]   ErrAddr
);

  localparam int         BEAT_BYTES  = DATA_W / 8;
  localparam int         BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam logic [7:0] LAST_BEAT   = 8'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [15:0]         burstIdx_q, burstIdx_d;
  logic [7:0]          beatIdx_q, beatIdx_d;
  logic [31:0]         seed_q, seed_d;
  logic [15:0]         burstNum_q, burstNum_d;
  logic [15:0]         errCnt_q, errCnt_d;
  logic [ADDR_W-1:0]   errAddr_q, errAddr_d;

  logic [ADDR_W-1:0]   burstAddr;
  logic [ADDR_W-1:0]   beatAddr;
  logic [31:0]         beatKey;
  logic                lastBeat;
  logic                lastBurst;
  logic                beatErr;
  logic [DATA_W-1:0]   wrWord;
  logic [DATA_W-1:0]   expWord;
  logic                unusedIds;

  assign burstAddr = BASE_ADDR + ADDR_W'(64'(burstIdx_q) * 64'(BURST_BYTES));
  assign beatAddr  = burstAddr + ADDR_W'(32'(beatIdx_q) * 32'(BEAT_BYTES));
  assign beatKey   = 32'(burstIdx_q) * 32'(BURST_LEN) + 32'(beatIdx_q);
  assign lastBeat  = (beatIdx_q == LAST_BEAT);
  assign lastBurst = (burstIdx_q == burstNum_q - 16'd1);
  assign unusedIds = ^{DdrCtrl_BID, DdrCtrl_RID};

  ddr_pattern_gen #(.DATA_W(DATA_W)) uWrGen (
    .seed_i    (seed_q),
    .beatKey_i (beatKey),
    .word_o    (wrWord)
  );

  ddr_pattern_gen #(.DATA_W(DATA_W)) uRdGen (
    .seed_i    (seed_q),
    .beatKey_i (beatKey),
    .word_o    (expWord)
  );

  assign beatErr = (DdrCtrl_RDATA != expWord) || (DdrCtrl_RRESP != 2'b00) ||
                   (DdrCtrl_RLAST != lastBeat);

  assign DdrCtrl_AVALID = (state_q == ST_WR_ADDR) || (state_q == ST_RD_ADDR);
  assign DdrCtrl_AADDR  = burstAddr;
  assign DdrCtrl_ATYPE  = (state_q == ST_WR_ADDR) ? ATYPE_WR : ATYPE_RD;
  assign DdrCtrl_ALEN   = LAST_BEAT;
  assign DdrCtrl_ASIZE  = asizeFromWidth(DATA_W);
  assign DdrCtrl_ABURST = ABURST_INCR;
  assign DdrCtrl_ALOCK  = 2'b00;
  assign DdrCtrl_AID    = 8'd0;
  assign DdrCtrl_WID    = 8'd0;
  assign DdrCtrl_WVALID = (state_q == ST_WR_DATA);
  assign DdrCtrl_WDATA  = wrWord;
  assign DdrCtrl_WSTRB  = '1;
  assign DdrCtrl_WLAST  = (state_q == ST_WR_DATA) && lastBeat;
  assign DdrCtrl_BREADY = (state_q == ST_WR_RESP);
  assign DdrCtrl_RREADY = (state_q == ST_RD_DATA);

  assign Busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign Done    = (state_q == ST_DONE);
  assign Pass    = Done && (errCnt_q == 16'd0);
  assign ErrCnt  = errCnt_q;
  assign ErrAddr = errAddr_q;

  // Sequencer: step through write bursts, read bursts, then score each read beat.
  always_comb begin
    state_d    = state_q;
    burstIdx_d = burstIdx_q;
    beatIdx_d  = beatIdx_q;
    seed_d     = seed_q;
    burstNum_d = burstNum_q;
    errCnt_d   = errCnt_q;
    errAddr_d  = errAddr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          seed_d     = PatSeed;
          burstNum_d = BurstNum;
          burstIdx_d = 16'd0;
          beatIdx_d  = 8'd0;
          errCnt_d   = 16'd0;
          errAddr_d  = '0;
          state_d    = (BurstNum == 16'd0) ? ST_DONE : ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (DdrCtrl_AREADY) begin
          beatIdx_d = 8'd0;
          state_d   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (DdrCtrl_WREADY) begin
          if (lastBeat) begin
            beatIdx_d = 8'd0;
            state_d   = ST_WR_RESP;
          end else begin
            beatIdx_d = beatIdx_q + 8'd1;
          end
        end
      end
      ST_WR_RESP: begin
        if (DdrCtrl_BVALID) begin
          if (lastBurst) begin
            burstIdx_d = 16'd0;
            state_d    = ST_RD_ADDR;
          end else begin
            burstIdx_d = burstIdx_q + 16'd1;
            state_d    = ST_WR_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (DdrCtrl_AREADY) begin
          beatIdx_d = 8'd0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (DdrCtrl_RVALID) begin
          if (beatErr) begin
            if (errCnt_q == 16'd0) begin
              errAddr_d = beatAddr;
            end
            if (errCnt_q != 16'hFFFF) begin
              errCnt_d = errCnt_q + 16'd1;
            end
          end
          if (lastBeat) begin
            beatIdx_d = 8'd0;
            if (lastBurst) begin
              state_d = ST_CHECK;
            end else begin
              burstIdx_d = burstIdx_q + 16'd1;
              state_d    = ST_RD_ADDR;
            end
          end else begin
            beatIdx_d = beatIdx_q + 8'd1;
          end
        end
      end
      ST_CHECK: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered compare results.
  always_ff @(posedge Axi0Clk or negedge Axi0Rstn) begin
    if (!Axi0Rstn) begin
      state_q    <= ST_IDLE;
      burstIdx_q <= 16'd0;
      beatIdx_q  <= 8'd0;
      seed_q     <= 32'd0;
      burstNum_q <= 16'd0;
      errCnt_q   <= 16'd0;
      errAddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      burstIdx_q <= burstIdx_d;
      beatIdx_q  <= beatIdx_d;
      seed_q     <= seed_d;
      burstNum_q <= burstNum_d;
      errCnt_q   <= errCnt_d;
      errAddr_q  <= errAddr_d;
    end
  end

endmodule

// File: doc/ddr_axi_pattern_tester.md
Name: ddr_axi_pattern_tester

Overview:
- AXI traffic generator and checker for DDR controller port 0 (256-bit, combined address channel AVALID/AREADY/ATYPE).
- Sits directly upstream of the controller: on Start it writes BurstNum INCR bursts of a deterministic pattern, reads them back, and compares.
- Reports Busy/Done/Pass, an error count and the first failing address to the debug/JTAG logic and LEDs.

Parameters:
- DATA_W, 256, AXI data width in bits (multiple of 32).
- ADDR_W, 32, AXI address width.
- BURST_LEN, 16, beats per burst (1..256); ALEN = BURST_LEN-1.
- BASE_ADDR, 32'h0000_0000, byte address of the first burst.

Ports:
- Axi0Clk, in, 1, sole clock.
- Axi0Rstn, in, 1, asynchronous active-low reset.
- Start, in, 1, single-cycle start request.
- PatSeed, in, 32, pattern seed; sampled on accepted Start.
- BurstNum, in, 16, number of bursts; sampled on accepted Start.
- DdrCtrl_AVALID / DdrCtrl_AREADY, out/in, 1, address handshake.
- DdrCtrl_AADDR, out, ADDR_W, burst byte address.
- DdrCtrl_ATYPE, out, 1, 1=write, 0=read.
- DdrCtrl_ALEN, out, 8, BURST_LEN-1.
- DdrCtrl_ASIZE, out, 3, log2(DATA_W/8).
- DdrCtrl_ABURST, out, 2, 2'b01.
- DdrCtrl_ALOCK, out, 2, 2'b00.
- DdrCtrl_AID, out, 8, 0.
- DdrCtrl_WID, out, 8, 0.
- DdrCtrl_WVALID / DdrCtrl_WREADY, out/in, 1, write data handshake.
- DdrCtrl_WDATA, out, DATA_W, write data.
- DdrCtrl_WSTRB, out, DATA_W/8, all ones.
- DdrCtrl_WLAST, out, 1, last write beat.
- DdrCtrl_BVALID / DdrCtrl_BREADY, in/out, 1, write response; DdrCtrl_BID (in, 8) is ignored.
- DdrCtrl_RVALID / DdrCtrl_RREADY, in/out, 1, read data handshake.
- DdrCtrl_RDATA, in, DATA_W, read data.
- DdrCtrl_RLAST, in, 1, last read beat.
- DdrCtrl_RRESP, in, 2, read response.
- DdrCtrl_RID, in, 8, ignored.
- Busy, out, 1, test running.
- Done, out, 1, test finished; held until next accepted Start.
- Pass, out, 1, Done and ErrCnt==0.
- ErrCnt, out, 16, saturating error count.
- ErrAddr, out, ADDR_W, byte address of first failing beat.

Behaviour:
- Reset (async assert, sync release): all valid/ready outputs 0; Busy, Done, Pass, ErrCnt, ErrAddr = 0; FSM = IDLE. Reset mid-burst abandons the transaction with no completion.
- Start is accepted only in IDLE or DONE. Acceptance clears Done, Pass, ErrCnt and ErrAddr; Start is ignored while Busy.
- FSM: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (next burst: WR_ADDR | all written: RD_ADDR) -> RD_DATA -> (next burst: RD_ADDR | all read: CHECK) -> DONE.
- BurstNum==0: go directly to DONE one cycle after Start, with Pass=1.
- Burst b address = BASE_ADDR + b*BURST_LEN*(DATA_W/8), modulo 2^ADDR_W.
- AVALID is held with stable AADDR/ATYPE until AREADY. AVALID is asserted the cycle after entering WR_ADDR/RD_ADDR.
- WVALID is asserted only after the address is accepted. Data is held stable until WREADY. WLAST=1 on beat BURST_LEN-1.
- BREADY=1 only in WR_RESP. BVALID completes the burst.
- RREADY=1 throughout RD_DATA. The burst ends on the beat counter reaching BURST_LEN-1.
- Pattern for global beat k = b*BURST_LEN + beat: 32-bit lane i = PatSeed + k*(DATA_W/32) + i, mod 2^32. The read side regenerates the identical value.
- Per-beat error: data mismatch, OR RRESP != 0, OR RLAST != (beat == BURST_LEN-1).
- Compare is registered, so ErrCnt updates one cycle after the beat.
- ErrCnt saturates at 16'hFFFF.
- ErrAddr = burst address + beat*(DATA_W/8), captured only on the first error.
- CHECK lasts one cycle to flush the compare pipeline. Then DONE: Busy=0, Done=1, Pass=(ErrCnt==0).
- Busy=1 from the cycle after Start through CHECK.

Decomposition:
- Shared package ddr_test_pkg: FSM state enum, ABURST_INCR, ATYPE_WR/ATYPE_RD constants, and the function deriving ASIZE from DATA_W.
- Sub-module ddr_pattern_gen: combinational (PatSeed, k) -> DATA_W word. It is instantiated twice, once for write generation and once for read expectation.

Test Plan:
- BurstNum=1, PatSeed=0, ideal memory model -> beat 0 lane 1 = 32'h1, beat 15 lane 7 = 32'h7F; Done=1, Pass=1, ErrCnt=0.
- BurstNum=4 with random AREADY/WREADY/BVALID/RVALID stalls (≈50%) -> address and data stable under stall; 64 beats checked; Pass=1.
- BurstNum=4, model flips RDATA bit 0 on burst 2 beat 3 -> ErrCnt=1, ErrAddr=32'h460, Pass=0.
- RRESP=2'b10 on burst 0 beat 0 and a missing RLAST on burst 1 -> ErrCnt=2, ErrAddr=32'h0.
- BurstNum=0 -> Done=1, Pass=1 one cycle after Start, with no AVALID. A second Start pulsed while Busy -> ignored; run count is unchanged.
- Axi0Rstn asserted mid WR_DATA -> AVALID/WVALID drop immediately and Busy=0. A later Start runs a clean pass.
